// File: rtl/freq_counter_pkg.sv
// Shared types and tdata layout for the multi-channel frequency counter.
// Beat layout, LSB first: count | channel index | component ID.
package freq_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsm_state_e;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned CH_IDX_W  = 8;
    localparam int unsigned COUNT_LSB = 0;

    // Bit offset of the channel-index field for a given count width.
    function automatic int unsigned idx_lsb(input int unsigned count_width);
        return count_width;
    endfunction

    // Bit offset of the component-ID field for a given count width.
    function automatic int unsigned id_lsb(input int unsigned count_width);
        return count_width + CH_IDX_W;
    endfunction

endpackage

// File: rtl/freq_counter_mc_edge_counter.sv
// One channel: synchroniser chain, rising-edge detect, edge counter.
// Optional feature macro: FREQ_COUNTER_MC_SATURATE_EN (counter saturates
// instead of wrapping).
module freq_edge_counter #(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pulse_in,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   edge_det;

    // Next state for synchroniser, edge detector and counter.
    // count_o includes this cycle's edge so a snapshot taken on clear sees it.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pulse_in};
        prev_d   = sync_q[SYNC_STAGES-1];
        edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
`ifdef FREQ_COUNTER_MC_SATURATE_EN
        if (edge_det && (cnt_q != '1)) begin
            count_o = cnt_q + 1'b1;
        end else begin
            count_o = cnt_q;
        end
`else
        count_o = edge_det ? cnt_q + 1'b1 : cnt_q;
`endif
        cnt_d = clear ? '0 : count_o;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel frequency counter with AXI-Stream result output.
// Every GATE_CYCLES clocks all channel counts are snapshotted and sent as
// one frame of CHANNELS beats; a window arriving mid-frame is dropped and
// flagged on the sticky overrun output.
// Optional feature macro: FREQ_COUNTER_MC_SATURATE_EN (see freq_edge_counter).
module freq_counter_mc
    import freq_counter_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned COUNT_WIDTH  = 32,
    parameter int unsigned GATE_CYCLES  = 100_000_000,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [7:0]  COMPONENT_ID = 8'h7F
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHANNELS-1:0]     pulse_signal,
    output logic [COUNT_WIDTH+15:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    overrun
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CH_IDX_W-1:0] CH_LAST   = CH_IDX_W'(CHANNELS - 1);

    logic [GATE_W-1:0]               gate_q, gate_d;
    logic                            snap_evt;
    logic [CHANNELS*COUNT_WIDTH-1:0] count_now;
    logic [CHANNELS*COUNT_WIDTH-1:0] snap_q, snap_d;
    fsm_state_e                      state_q, state_d;
    logic [CH_IDX_W-1:0]             ch_q, ch_d;
    logic                            overrun_q, overrun_d;
    logic                            hs;
    logic                            last_beat;
    logic [COUNT_WIDTH-1:0]          sel_count;

    // Free-running gate counter; wraps at the end of every window.
    always_comb begin
        snap_evt = (gate_q == GATE_LAST);
        gate_d   = snap_evt ? '0 : gate_q + 1'b1;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        freq_edge_counter #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_edge_counter (
            .clk      (clk),
            .rst_n    (rst_n),
            .pulse_in (pulse_signal[g]),
            .clear    (snap_evt),
            .count_o  (count_now[g*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

    // Output FSM next state. A snapshot is accepted only when idle or in the
    // very cycle the final beat hands off, so a new frame follows back-to-back.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;
        hs        = (state_q == SEND) && m_axis_tready;
        last_beat = (ch_q == CH_LAST);
        case (state_q)
            IDLE: begin
                if (snap_evt) begin
                    state_d = SEND;
                    ch_d    = '0;
                    snap_d  = count_now;
                end
            end
            SEND: begin
                if (hs) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        ch_d    = '0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
                if (snap_evt) begin
                    if (hs && last_beat) begin
                        state_d = SEND;
                        ch_d    = '0;
                        snap_d  = count_now;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat assembly; tdata is zero whenever no beat is offered.
    always_comb begin
        sel_count = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (ch_q == CH_IDX_W'(i)) begin
                sel_count = snap_q[i*COUNT_WIDTH +: COUNT_WIDTH];
            end
        end
        m_axis_tvalid = (state_q == SEND);
        m_axis_tlast  = m_axis_tvalid && (ch_q == CH_LAST);
        m_axis_tdata  = '0;
        if (m_axis_tvalid) begin
            m_axis_tdata[COUNT_LSB +: COUNT_WIDTH]          = sel_count;
            m_axis_tdata[idx_lsb(COUNT_WIDTH) +: CH_IDX_W]  = ch_q;
            m_axis_tdata[id_lsb(COUNT_WIDTH) +: ID_W]       = COMPONENT_ID;
        end
        overrun = overrun_q;
    end

    // Gate, snapshot and FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q    <= '0;
            snap_q    <= '0;
            state_q   <= IDLE;
            ch_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            gate_q    <= gate_d;
            snap_q    <= snap_d;
            state_q   <= state_d;
            ch_q      <= ch_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: doc/freq_counter_mc.md
FREQ_COUNTER_MC -- requirements
Module: freq_counter_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent pulse inputs (1..16).
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, per-channel edge-counter width (4..32).
REQ-003 SHALL have parameter GATE_CYCLES, default 100_000_000, measurement window length in clk cycles (>=2*CHANNELS+4).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-005 SHALL have parameter COMPONENT_ID, default 8'h7F, destination ID placed in every output beat.
REQ-006 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port pulse_signal  input  CHANNELS  asynchronous pulse inputs, one bit per channel.
REQ-009 SHALL have port m_axis_tdata  output  COUNT_WIDTH+16  {COMPONENT_ID[7:0], channel index[7:0], count}.
REQ-010 SHALL have port m_axis_tvalid  output  1  beat valid.
REQ-011 SHALL have port m_axis_tready  input  1  sink ready.
REQ-012 SHALL have port m_axis_tlast  output  1  high on channel CHANNELS-1 beat.
REQ-013 SHALL have port overrun  output  1  sticky: a window result was dropped.

Function
REQ-014 Each channel SHALL pass through SYNC_STAGES flops then rising-edge detect (prev flop); one edge = one count.
REQ-015 Gate counter SHALL run 0..GATE_CYCLES-1 continuously, wrapping to 0.
REQ-016 On gate count GATE_CYCLES-1, all channel counts including that cycle's edge SHALL be snapshotted; counters SHALL load 0 (edge in next cycle counts into new window).
REQ-017 Output FSM states: IDLE, SEND; IDLE->SEND the cycle after snapshot, tvalid high that cycle (latency 1 clk).
REQ-018 SEND SHALL emit channels 0..CHANNELS-1 in order, one beat per tvalid&&tready, tdata/tlast held stable while tvalid&&!tready.
REQ-019 After the tlast handshake SHALL return to IDLE, tvalid low next cycle unless a snapshot is pending that same cycle, in which case SEND continues with channel 0.
REQ-020 Snapshot occurring while in SEND (not in the final-beat handshake cycle) SHALL be discarded, overrun set; frame in flight unaffected.
REQ-021 overrun SHALL clear only by reset.
REQ-022 Counting SHALL never stall due to output back-pressure.

Reset
REQ-023 rst_n low SHALL immediately force: tvalid 0, tlast 0, tdata 0, overrun 0, FSM IDLE, gate/edge/sync/snapshot registers 0.
REQ-024 Reset mid-frame SHALL abort the frame; first window after release SHALL be a full GATE_CYCLES window; an input high at release counts one edge.

Configuration
REQ-025 Macro FREQ_COUNTER_MC_SATURATE_EN defined: per-channel counter SHALL saturate at 2**COUNT_WIDTH-1.
REQ-026 Macro undefined: counter SHALL wrap modulo 2**COUNT_WIDTH.

Structure
REQ-027 Package freq_counter_pkg SHALL hold FSM state enum, tdata field widths/offsets, channel-index width constant.
REQ-028 Sub-module freq_edge_counter SHALL implement one channel (synchroniser, edge detect, counter), instantiated CHANNELS times via generate.

Verification (CHANNELS=4, COUNT_WIDTH=32, GATE_CYCLES=100 unless stated)
REQ-029 ch0 1-clk pulse every 4 clks, ch1 every 5, ch2 tied 0, ch3 tied 1, tready=1 -> frames {7F,00,25},{7F,01,20},{7F,02,0},{7F,03,0} (ch3 1 first window only), tlast on ch3.
REQ-030 tready low 250 clks after first snapshot -> frame 1 beat 0 held stable, two windows dropped, overrun=1, next frame carries window 4 counts.
REQ-031 COUNT_WIDTH=4, pulse every 2 clks (50 edges) -> 15 with FREQ_COUNTER_MC_SATURATE_EN, 2 without.
REQ-032 rst_n low for 3 clks during beat 2 of a frame -> tvalid 0 during reset, overrun 0, next frame exactly 101 clks after release.
REQ-033 Random 70%-high input (re-sampled per clk) on all channels, random tready -> every count equals reference-model rising-edge count per window, no beat lost/duplicated.
